motor_ramp_sequencer: RTL and testbench

MOTOR_RAMP_SEQUENCER -- requirements
Module: motor_ramp_sequencer

---
 rtl/motor_ramp_sequencer_pkg.sv | 5 +
 rtl/motor_ramp_sequencer_if.sv | 13 +
 rtl/ramp_tick_gen.sv | 18 +
 rtl/motor_ramp_sequencer.sv | 82 ++++++++
 tb/tb_motor_ramp_sequencer.sv | 136 +++++++++++++
 5 files changed

// File: rtl/motor_ramp_sequencer_pkg.sv
// motor_pkg: shared state encoding and default speed-word width for the ramp sequencer.
package motor_pkg;
   localparam int DEF_WIDTH = 8;
   typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, HOLD} state_e;
endpackage

// File: rtl/motor_ramp_sequencer_if.sv
// motor_ramp_sequencer_if: command handshake, estop and PWM-facing outputs of the sequencer.
interface motor_ramp_sequencer_if #(parameter int WIDTH = motor_pkg::DEF_WIDTH);
   logic             cmd_valid;
   logic [WIDTH-1:0] cmd_speed;
   logic             cmd_ready;
   logic             estop;
   logic [WIDTH-1:0] speed;
   logic             enable;
   logic             busy;
   logic             at_target;
   modport master (output cmd_valid, cmd_speed, estop, input cmd_ready, speed, enable, busy, at_target);
   modport slave (input cmd_valid, cmd_speed, estop, output cmd_ready, speed, enable, busy, at_target);
endinterface

// File: rtl/ramp_tick_gen.sv
// ramp_tick_gen: counts 0..DIV-1 while run is high and pulses tick on the wrap cycle.
module ramp_tick_gen #(
   parameter int DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic tick
);
   localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   assign tick  = run & (cnt_q == CW'(DIV - 1));
   assign cnt_d = (clr || !run || tick) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/motor_ramp_sequencer.sv
// motor_ramp_sequencer: ramps a registered PWM duty word toward a commanded target in
// RAMP_STEP increments every RAMP_DIV cycles, with a level-sensitive emergency stop.
module motor_ramp_sequencer
   import motor_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int RAMP_DIV  = 16,
   parameter int RAMP_STEP = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   motor_ramp_sequencer_if.slave bus
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] speed_q, speed_d, target_q, target_d, ramp_speed;
   logic             enable_q, enable_d, busy_q, busy_d, at_target_q, at_target_d, ready_q, ready_d;
   logic             accept, tick;
   logic [WIDTH:0]   step_w, up_sum, dn_diff;
   // estop gates ready without a cycle of delay so no command slips in on the estop edge
   assign bus.cmd_ready = ready_q & ~bus.estop;
   assign bus.speed     = speed_q;
   assign bus.enable    = enable_q;
   assign bus.busy      = busy_q;
   assign bus.at_target = at_target_q;
   assign accept  = bus.cmd_valid & bus.cmd_ready;
   assign step_w  = (WIDTH + 1)'(RAMP_STEP);
   assign up_sum  = {1'b0, speed_q} + step_w;
   assign dn_diff = {1'b0, speed_q} - step_w;
   // the extra top bit catches both overflow on the way up and underflow on the way down
   assign ramp_speed = (state_q == RAMP_UP)
      ? ((up_sum > {1'b0, target_q}) ? target_q : up_sum[WIDTH-1:0])
      : ((dn_diff[WIDTH] || dn_diff < {1'b0, target_q}) ? target_q : dn_diff[WIDTH-1:0]);
   ramp_tick_gen #(.DIV(RAMP_DIV)) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (accept | bus.estop),
      .run  (busy_q),
      .tick (tick)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= IDLE;
         speed_q     <= '0;
         target_q    <= '0;
         enable_q    <= 1'b0;
         busy_q      <= 1'b0;
         at_target_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         speed_q     <= speed_d;
         target_q    <= target_d;
         enable_q    <= enable_d;
         busy_q      <= busy_d;
         at_target_q <= at_target_d;
         ready_q     <= ready_d;
      end
   always_comb begin
      state_d  = state_q;
      speed_d  = speed_q;
      target_d = target_q;
      if (bus.estop) begin
         state_d  = IDLE;
         speed_d  = '0;
         target_d = '0;
      end else if (accept) begin
         target_d = bus.cmd_speed;
         state_d  = (bus.cmd_speed > speed_q) ? RAMP_UP
                  : (bus.cmd_speed < speed_q) ? RAMP_DOWN
                  : (bus.cmd_speed != '0) ? HOLD : IDLE;
      end else if (tick) begin
         speed_d = ramp_speed;
         state_d = (ramp_speed != target_q) ? state_q : (target_q != '0) ? HOLD : IDLE;
      end
   end
   always_comb begin
      enable_d    = state_d != IDLE;
      busy_d      = state_d == RAMP_UP || state_d == RAMP_DOWN;
      at_target_d = state_d == HOLD;
      ready_d     = (state_d == IDLE || state_d == HOLD) && !bus.estop;
   end
endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// tb_motor_ramp_sequencer: directed ramp, clamp, stall, estop and async-reset checks
// with RAMP_DIV=4 and RAMP_STEP=16.
module tb_motor_ramp_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   motor_ramp_sequencer_if #(.WIDTH(8)) bus ();
   motor_ramp_sequencer #(.WIDTH(8), .RAMP_DIV(4), .RAMP_STEP(16)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic step_chk(input string tag, input logic [31:0] exp);
      repeat (4) @(negedge clk);
      chk(tag, 32'(bus.speed), exp);
   endtask
   task automatic send(input logic [7:0] v);
      bus.cmd_speed = v;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask
   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_speed = '0;
      bus.estop     = 1'b0;
      #3;
      chk("rst_speed", 32'(bus.speed), 0);
      chk("rst_enable", 32'(bus.enable), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_at_target", 32'(bus.at_target), 0);
      chk("rst_ready", 32'(bus.cmd_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(bus.cmd_ready), 1);
      send(8'd64);
      chk("up64_enable", 32'(bus.enable), 1);
      chk("up64_busy", 32'(bus.busy), 1);
      chk("up64_ready", 32'(bus.cmd_ready), 0);
      repeat (3) @(negedge clk);
      chk("up64_latency", 32'(bus.speed), 0);
      @(negedge clk);
      chk("up64_s1", 32'(bus.speed), 16);
      step_chk("up64_s2", 32);
      step_chk("up64_s3", 48);
      step_chk("up64_s4", 64);
      chk("up64_at_target", 32'(bus.at_target), 1);
      chk("up64_busy_end", 32'(bus.busy), 0);
      chk("up64_enable_end", 32'(bus.enable), 1);
      chk("up64_ready_end", 32'(bus.cmd_ready), 1);
      send(8'd100);
      step_chk("up100_s1", 80);
      step_chk("up100_s2", 96);
      step_chk("up100_clamp", 100);
      chk("up100_at_target", 32'(bus.at_target), 1);
      send(8'd0);
      for (int i = 0; i < 6; i++) step_chk("dn0_step", 32'(84 - 16 * i));
      step_chk("dn0_floor", 0);
      chk("dn0_enable", 32'(bus.enable), 0);
      chk("dn0_busy", 32'(bus.busy), 0);
      chk("dn0_at_target", 32'(bus.at_target), 0);
      chk("dn0_ready", 32'(bus.cmd_ready), 1);
      send(8'd240);
      repeat (60) @(negedge clk);
      chk("up240_speed", 32'(bus.speed), 240);
      chk("up240_at_target", 32'(bus.at_target), 1);
      bus.cmd_speed = 8'd255;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_speed = 8'd224;
      repeat (2) @(negedge clk);
      chk("stall_ready", 32'(bus.cmd_ready), 0);
      chk("stall_speed", 32'(bus.speed), 240);
      repeat (2) @(negedge clk);
      chk("up255_nowrap", 32'(bus.speed), 255);
      chk("up255_at_target", 32'(bus.at_target), 1);
      chk("held_ready", 32'(bus.cmd_ready), 1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("held_accepted", 32'(bus.busy), 1);
      step_chk("dn224_s1", 239);
      step_chk("dn224_clamp", 224);
      chk("dn224_at_target", 32'(bus.at_target), 1);
      send(8'd64);
      step_chk("estop_pre", 208);
      repeat (2) @(negedge clk);
      bus.estop     = 1'b1;
      bus.cmd_speed = 8'd50;
      bus.cmd_valid = 1'b1;
      #1;
      chk("estop_ready_now", 32'(bus.cmd_ready), 0);
      @(negedge clk);
      chk("estop_speed", 32'(bus.speed), 0);
      chk("estop_enable", 32'(bus.enable), 0);
      chk("estop_busy", 32'(bus.busy), 0);
      chk("estop_at_target", 32'(bus.at_target), 0);
      chk("estop_ready", 32'(bus.cmd_ready), 0);
      repeat (2) @(negedge clk);
      chk("estop_hold_speed", 32'(bus.speed), 0);
      chk("estop_hold_enable", 32'(bus.enable), 0);
      bus.estop     = 1'b0;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("estop_release_ready", 32'(bus.cmd_ready), 1);
      chk("estop_no_accept", 32'(bus.enable), 0);
      send(8'd128);
      repeat (4) @(negedge clk);
      chk("arst_pre", 32'(bus.speed), 16);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_speed", 32'(bus.speed), 0);
      chk("arst_enable", 32'(bus.enable), 0);
      chk("arst_busy", 32'(bus.busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_ready", 32'(bus.cmd_ready), 1);
      send(8'd32);
      step_chk("fresh_s1", 16);
      step_chk("fresh_s2", 32);
      chk("fresh_at_target", 32'(bus.at_target), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
